// File: rtl/trace_pkg.sv
// Shared types for the retire trace unit: record kinds, FSM states, the packed
// trace record and the retire classifier.
package trace_pkg;

  // The record's inum field width; the top casts its CNT_W counter into it.
  localparam int INUM_W = 32;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_HALT = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_STOP
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [INUM_W-1:0] inum;
    logic [15:0]       pc;
    logic [3:0]        regNum;
    logic [15:0]       val;
    logic [15:0]       addr;
  } trace_rec_t;

  // Priority: load, register write, halt, store, then everything else.
  function automatic trace_rec_t classify(
    input logic [15:0]       pc,
    input logic              regWrite,
    input logic [3:0]        wrReg,
    input logic [15:0]       wrData,
    input logic              memRead,
    input logic              memWrite,
    input logic [15:0]       memAddr,
    input logic [15:0]       memData,
    input logic              hlt,
    input logic [INUM_W-1:0] inum
  );
    trace_rec_t r;
    r      = '0;
    r.pc   = pc;
    r.inum = inum;
    if (regWrite && memRead) begin
      r.kind   = KIND_LD;
      r.regNum = wrReg;
      r.val    = wrData;
      r.addr   = memAddr;
    end else if (regWrite) begin
      r.kind   = KIND_REG;
      r.regNum = wrReg;
      r.val    = wrData;
    end else if (hlt) begin
      r.kind = KIND_HALT;
    end else if (memWrite) begin
      r.kind = KIND_ST;
      r.val  = memData;
      r.addr = memAddr;
    end else begin
      r.kind = KIND_NOP;
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; pointers carry one extra wrap bit so
// full/empty are told apart by the MSB.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  trace_rec_t pushRec,
  output trace_rec_t headRec,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        doPush;
  logic        doPop;
  trace_rec_t  mem [DEPTH];

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushRec;
  end

  assign headRec = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/retire_trace_unit.sv
// Retire monitor: classifies each committed instruction, numbers it, and queues
// a trace record. Optional macro TRACE_FILTER_NOP_EN suppresses NOP records.
module retire_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pc,
  input  logic             reg_write,
  input  logic [3:0]       wr_reg,
  input  logic [15:0]      wr_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             hlt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_kind,
  output logic [CNT_W-1:0] rec_inum,
  output logic [15:0]      rec_pc,
  output logic [3:0]       rec_reg,
  output logic [15:0]      rec_val,
  output logic [15:0]      rec_addr,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             done,
  output logic             timeout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   LIM_ONE = 1;
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(CYCLE_LIMIT);

  state_e           state;
  state_e           stateNext;
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] instCnt;
  logic             timeoutQ;
  logic             overflowQ;
  logic             haltHeld;
  trace_rec_t       heldRec;

  trace_rec_t curRec;
  trace_rec_t pushRec;
  trace_rec_t headRec;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       doPop;
  logic       doPush;
  logic       space;
  logic       isHalt;
  logic       limitHit;
  logic       wantRec;
  logic       countEn;
  logic       dropRec;
  logic       holdHalt;
  logic       setTimeout;

  assign curRec = classify(pc, reg_write, wr_reg, wr_data, mem_read, mem_write,
                           mem_addr, mem_data, hlt, INUM_W'(instCnt));
  assign isHalt   = (curRec.kind == KIND_HALT);
  assign limitHit = ({1'b0, cycleCnt} + LIM_ONE) > LIMIT;
  assign doPop    = !fifoEmpty && rec_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign space    = !fifoFull || doPop;

`ifdef TRACE_FILTER_NOP_EN
  assign wantRec = (curRec.kind != KIND_NOP);
`else
  assign wantRec = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    stateNext  = state;
    pushRec    = curRec;
    doPush     = 1'b0;
    countEn    = 1'b0;
    dropRec    = 1'b0;
    holdHalt   = 1'b0;
    setTimeout = 1'b0;
    case (state)
      ST_RUN: begin
        if (isHalt) begin
          stateNext = ST_DRAIN;
          countEn   = 1'b1;
          if (space) doPush   = 1'b1;
          else       holdHalt = 1'b1;
        end else if (limitHit) begin
          stateNext  = ST_STOP;
          setTimeout = 1'b1;
        end else begin
          countEn = 1'b1;
          if (wantRec) begin
            if (space) doPush  = 1'b1;
            else       dropRec = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        pushRec = heldRec;
        if (haltHeld && space) doPush = 1'b1;
        if (doPop && headRec.kind == KIND_HALT) stateNext = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      timeoutQ  <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (setTimeout) timeoutQ  <= 1'b1;
      if (dropRec)    overflowQ <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= '0;
      instCnt  <= '0;
    end else if (countEn) begin
      if (cycleCnt != CNT_MAX) cycleCnt <= cycleCnt + CNT_ONE;
      if (instCnt  != CNT_MAX) instCnt  <= instCnt + CNT_ONE;
    end
  end

  // A HALT that meets a full FIFO waits here until a slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haltHeld <= 1'b0;
      heldRec  <= '0;
    end else if (holdHalt) begin
      haltHeld <= 1'b1;
      heldRec  <= curRec;
    end else if (state == ST_DRAIN && doPush) begin
      haltHeld <= 1'b0;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (doPush),
    .pop     (doPop),
    .pushRec (pushRec),
    .headRec (headRec),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign rec_valid   = !fifoEmpty;
  assign rec_kind    = headRec.kind;
  assign rec_inum    = CNT_W'(headRec.inum);
  assign rec_pc      = headRec.pc;
  assign rec_reg     = headRec.regNum;
  assign rec_val     = headRec.val;
  assign rec_addr    = headRec.addr;
  assign cycle_count = cycleCnt;
  assign inst_count  = instCnt;
  assign done        = (state == ST_DONE);
  assign timeout     = timeoutQ;
  assign overflow    = overflowQ;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a short-limit instance.
module tb_retire_trace_unit;

  localparam int DEPTH   = 8;
  localparam int LIMIT_A = 100000;
  localparam int K_NOP = 0, K_REG = 1, K_LD = 2, K_ST = 3, K_HALT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        hlt = 1'b0;
  logic        rec_ready = 1'b0;

  logic        rec_valid, done, timeout, overflow;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum, cycle_count, inst_count;
  logic [15:0] rec_pc, rec_val, rec_addr;
  logic [3:0]  rec_reg;

  logic        bValid, bDone, bTimeout, bOverflow;
  logic [2:0]  bKind;
  logic [31:0] bInum, bCycle, bInst;
  logic [15:0] bPc, bVal, bAddr;
  logic [3:0]  bReg;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  retire_trace_unit #(.DEPTH(DEPTH), .CNT_W(32), .CYCLE_LIMIT(LIMIT_A)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg),
    .wr_data(wr_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .hlt(hlt), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg),
    .rec_val(rec_val), .rec_addr(rec_addr), .cycle_count(cycle_count),
    .inst_count(inst_count), .done(done), .timeout(timeout), .overflow(overflow)
  );

  retire_trace_unit #(.DEPTH(DEPTH), .CNT_W(32), .CYCLE_LIMIT(20)) dutLim (
    .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg),
    .wr_data(wr_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .hlt(hlt), .rec_valid(bValid), .rec_ready(rec_ready),
    .rec_kind(bKind), .rec_inum(bInum), .rec_pc(bPc), .rec_reg(bReg),
    .rec_val(bVal), .rec_addr(bAddr), .cycle_count(bCycle),
    .inst_count(bInst), .done(bDone), .timeout(bTimeout), .overflow(bOverflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else nPass++;
  endtask

  // ---------------- reference model (spec-level, queue based) ----------------
  typedef struct {
    int kind;
    longint inum;
    int pc, rg, val, addr;
  } exp_t;

  exp_t   expQ[$];
  exp_t   mHeldRec;
  bit     mHalted, mStopped, mHeld, mDone, mOvf, mTimeout;
  longint mInst, mCyc;

  function automatic exp_t retired(input longint idx);
    exp_t e;
    e = '{kind: K_NOP, inum: idx, pc: int'(pc), rg: 0, val: 0, addr: 0};
    if (reg_write && mem_read)
      e = '{kind: K_LD, inum: idx, pc: int'(pc), rg: int'(wr_reg), val: int'(wr_data), addr: int'(mem_addr)};
    else if (reg_write)
      e = '{kind: K_REG, inum: idx, pc: int'(pc), rg: int'(wr_reg), val: int'(wr_data), addr: 0};
    else if (hlt)
      e.kind = K_HALT;
    else if (mem_write)
      e = '{kind: K_ST, inum: idx, pc: int'(pc), rg: 0, val: int'(mem_data), addr: int'(mem_addr)};
    return e;
  endfunction

  function automatic bit recorded(input int kind);
`ifdef TRACE_FILTER_NOP_EN
    return kind != K_NOP;
`else
    return kind >= 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
      {mHalted, mStopped, mHeld, mDone, mOvf, mTimeout} = '0;
      mInst = 0;
      mCyc  = 0;
    end else begin : model_step
      exp_t cur;
      exp_t gone;
      if (expQ.size() != 0 && rec_ready) begin
        gone = expQ.pop_front();
        if (gone.kind == K_HALT) mDone = 1;
      end
      if (!mHalted && !mStopped) begin
        cur = retired(mInst);
        if (cur.kind == K_HALT) begin
          mHalted = 1;
          mInst++; mCyc++;
          if (expQ.size() < DEPTH) expQ.push_back(cur);
          else begin mHeld = 1; mHeldRec = cur; end
        end else if (mCyc + 1 > LIMIT_A) begin
          mStopped = 1;
          mTimeout = 1;
        end else begin
          mInst++; mCyc++;
          if (recorded(cur.kind)) begin
            if (expQ.size() < DEPTH) expQ.push_back(cur);
            else mOvf = 1;
          end
        end
      end else if (mHeld && expQ.size() < DEPTH) begin
        expQ.push_back(mHeldRec);
        mHeld = 0;
      end
    end
  end

  // Single compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rec_valid", rec_valid, expQ.size() != 0);
      if (expQ.size() != 0) begin
        check("rec_kind", rec_kind, expQ[0].kind);
        check("rec_inum", rec_inum, expQ[0].inum);
        check("rec_pc",   rec_pc,   expQ[0].pc);
        check("rec_reg",  rec_reg,  expQ[0].rg);
        check("rec_val",  rec_val,  expQ[0].val);
        check("rec_addr", rec_addr, expQ[0].addr);
      end
      check("inst_count",  inst_count,  mInst);
      check("cycle_count", cycle_count, mCyc);
      check("done",        done,        mDone);
      check("timeout",     timeout,     mTimeout);
      check("overflow",    overflow,    mOvf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [15:0] p, input logic rw, input logic [3:0] r,
                       input logic [15:0] d, input logic mr, input logic mw,
                       input logic [15:0] a, input logic [15:0] md, input logic h);
    pc = p; reg_write = rw; wr_reg = r; wr_data = d;
    mem_read = mr; mem_write = mw; mem_addr = a; mem_data = md; hlt = h;
  endtask

  task automatic drvNop(input logic [15:0] p);
    drive(p, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; returns 1 ns after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    rec_ready = 1'b0;
    drvNop(16'h0000);
    tick();
    check("rst_valid", rec_valid, 0);
    check("rst_inst",  inst_count, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_flags", {done, timeout, overflow}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bNext;
    tick();

    // 1: REG, ST, HALT with the consumer always ready.
    doReset();
    rec_ready = 1'b1;
    drive(16'h0100, 1, 4'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
    tick();
    check("t1_reg_kind", rec_kind, K_REG);
    check("t1_reg_inum", rec_inum, 0);
    check("t1_reg_fields", {rec_reg, rec_val, rec_addr}, {4'd3, 16'h1234, 16'h0000});
    drive(16'h0102, 0, 4'd0, 16'h0000, 0, 1, 16'h0040, 16'h00AA, 0);
    tick();
    check("t1_st_kind", rec_kind, K_ST);
    check("t1_st_fields", {rec_inum, rec_addr, rec_val}, {32'd1, 16'h0040, 16'h00AA});
    drive(16'h0104, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
    tick();
    check("t1_halt_head", {rec_valid, rec_kind, rec_inum}, {1'b1, 3'd4, 32'd2});
    check("t1_inst_count", inst_count, 3);
    check("t1_done_early", done, 0);
    drvNop(16'h0106);
    tick();
    check("t1_done", done, 1);
    check("t1_empty", rec_valid, 0);
    tick();
    check("t1_done_hold", {done, inst_count}, {1'b1, 32'd3});

    // 2: twelve retires with the consumer stalled.
    doReset();
    for (int i = 0; i < 12; i++) begin
      drive(16'h0200 + 16'(i), 1, 4'(i), 16'(i), 0, 0, 0, 0, 0);
      tick();
    end
    check("t2_overflow", overflow, 1);
    check("t2_inst_count", inst_count, 12);
    rec_ready = 1'b1;
    drvNop(16'h0300);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_inum%0d", k), rec_inum, k);
      tick();
    end

    // 3: FIFO full when HALT retires; HALT waits and pops ninth.
    doReset();
    for (int i = 0; i < 8; i++) begin
      drive(16'h0400 + 16'(i), 1, 4'(i), 16'(i + 100), 0, 0, 0, 0, 0);
      tick();
    end
    check("t3_full_no_ovf", {overflow, inst_count}, {1'b0, 32'd8});
    drive(16'h0408, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("t3_halt_counted", inst_count, 9);
    drvNop(16'h0500);
    tick();
    check("t3_frozen", {inst_count, cycle_count}, {32'd9, 32'd9});
    rec_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t3_inum%0d", k), rec_inum, k);
      if (k == 8) check("t3_halt_kind", rec_kind, K_HALT);
      tick();
    end
    check("t3_done", {done, overflow}, {1'b1, 1'b0});

    // 4: limit-20 instance stops on its 21st RUN cycle.
    doReset();
    rec_ready = 1'b1;
    bNext = 0;
    for (int i = 0; i < 26; i++) begin
      if (bValid) begin
        check("t4_b_inum", bInum, bNext);
        bNext++;
      end
      drive(16'h0600 + 16'(i), 1, 4'd1, 16'(i), 0, 0, 0, 0, 0);
      tick();
      if (i == 19) check("t4_before", {bTimeout, bCycle}, {1'b0, 32'd20});
      if (i == 20) check("t4_after", {bTimeout, bCycle}, {1'b1, 32'd20});
    end
    check("t4_pushes", bNext, 20);
    check("t4_final", {bValid, bInst, bCycle}, {1'b0, 32'd20, 32'd20});

    // 5: load classification, then a NOP, then a REG.
    doReset();
    rec_ready = 1'b1;
    drive(16'h0700, 1, 4'd5, 16'hBEEF, 1, 0, 16'h0010, 16'h0000, 0);
    tick();
    check("t5_ld", {rec_kind, rec_reg, rec_val, rec_addr}, {3'd2, 4'd5, 16'hBEEF, 16'h0010});
    drvNop(16'h0702);
    tick();
`ifdef TRACE_FILTER_NOP_EN
    check("t5_nop_filtered", rec_valid, 0);
`else
    check("t5_nop_rec", {rec_valid, rec_kind, rec_inum}, {1'b1, 3'd0, 32'd1});
`endif
    drive(16'h0704, 1, 4'd2, 16'h0042, 0, 0, 0, 0, 0);
    tick();
    check("t5_next_inum", {rec_kind, rec_inum}, {3'd1, 32'd2});

    // 6: reset pulsed while draining clears everything without a clock edge.
    doReset();
    for (int i = 0; i < 10; i++) begin
      drive(16'h0800 + 16'(i), 1, 4'd7, 16'(i), 0, 0, 0, 0, 0);
      tick();
    end
    drive(16'h080A, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    rec_ready = 1'b1;
    drvNop(16'h0900);
    tick();
    check("t6_pre", {rec_valid, overflow}, {1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", rec_valid, 0);
    check("t6_async_counts", {inst_count, cycle_count}, 64'd0);
    check("t6_async_flags", {done, timeout, overflow}, 0);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Synthesizable on-chip retire monitor sitting directly downstream of the single-cycle cpu commit signals.
- Consumes the same per-cycle retire view: pc, register write, memory access and halt.
- Classifies each retired instruction and numbers it with a running instruction index.
- Buffers one trace record per instruction in a FIFO drained over a valid/ready port; keeps cycle and instruction counters and stops cleanly on halt or on a cycle limit.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of cycle, instruction and inum counters.
- CYCLE_LIMIT, 100000, cycle count above which the unit stops with timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  16  pc of the retiring instruction.
- reg_write  in  1  register file written this cycle.
- wr_reg  in  4  destination register.
- wr_data  in  16  data written to the register.
- mem_read  in  1  memory read this cycle.
- mem_write  in  1  memory write this cycle.
- mem_addr  in  16  memory address.
- mem_data  in  16  store data.
- hlt  in  1  halt retiring this cycle.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer accepts the head.
- rec_kind  out  3  record kind (package encoding).
- rec_inum  out  CNT_W  instruction index of the record.
- rec_pc  out  16  pc.
- rec_reg  out  4  register number; 0 when not applicable.
- rec_val  out  16  register or store value; 0 when not applicable.
- rec_addr  out  16  memory address; 0 when not applicable.
- cycle_count  out  CNT_W  cycles spent in RUN.
- inst_count  out  CNT_W  instructions retired.
- done  out  1  halt record has been drained.
- timeout  out  1  sticky; cycle limit exceeded.
- overflow  out  1  sticky; at least one record was dropped.

Behaviour:
- Reset (async, rst_n=0): FSM goes to RUN; FIFO is empty; all counters are 0; done, timeout, overflow and rec_valid are 0.
- Classification, in priority order:
  - reg_write & mem_read -> LD (reg, val = wr_data, addr = mem_addr).
  - reg_write -> REG (reg, val).
  - hlt -> HALT.
  - mem_write -> ST (addr, val = mem_data).
  - otherwise NOP (branch or nop).
- Counting in RUN, every cycle:
  - One instruction retires; its inum is the inst_count value before increment.
  - inst_count and cycle_count each increment by 1 and saturate at all-ones.
  - The record is pushed the same cycle it is captured; rec_valid rises the next cycle (latency 1).
- FIFO full: a push is accepted only if a pop (rec_valid & rec_ready) happens the same cycle. Otherwise the record is dropped, overflow is set, and inst_count still increments.
- A HALT record is never dropped. If the FIFO is full and there is no pop, HALT is held in a one-entry side register and pushed on the first free slot.
- FSM states:
  - RUN: a HALT classification -> DRAIN. If the next cycle_count would exceed CYCLE_LIMIT -> STOP with timeout=1 and no record pushed. Halt wins over timeout in the same cycle.
  - DRAIN: inputs ignored; counters frozen. When the HALT record pops -> DONE.
  - DONE: done=1; all outputs hold until reset.
  - STOP: inputs ignored; the FIFO continues to drain; holds until reset.
- The head record is stable while rec_valid=1 and rec_ready=0.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full and empty are decided by MSB compare.
- Reset asserted mid-operation: everything clears immediately and any undrained records are lost.

Optional Feature:
- Macro TRACE_FILTER_NOP_EN.
- Defined: NOP records are not pushed, but they still consume an inum and increment inst_count, so a gap appears in rec_inum.
- Undefined: every retired instruction produces a record.

Decomposition:
- Package trace_pkg holds:
  - Kind encodings: NOP=0, REG=1, LD=2, ST=3, HALT=4.
  - The packed record struct (kind, inum, pc, reg, val, addr).
- One sub-module, trace_fifo: a parameterized synchronous FIFO of trace_pkg records with push, pop, full, empty and head-out.

Test Plan:
1. REG then ST then HALT; rec_ready=1 throughout:
   - Records {REG,0,pc,r3,0x1234}, {ST,1,addr 0x0040,0x00AA}, {HALT,2}.
   - done=1 one cycle after HALT pops; inst_count=3.
2. rec_ready=0 for 12 retires with DEPTH=8:
   - 8 records held, overflow=1, inst_count=12.
   - After draining, the inums read 0..7.
3. FIFO full, and HALT retires while rec_ready=0:
   - HALT is not lost; it pops ninth once rec_ready=1, with its correct inum; done follows.
4. CYCLE_LIMIT=20 and no halt:
   - timeout=1 after cycle 21; cycle_count=20; no further pushes.
5. reg_write=1, mem_read=1, wr_data=0xBEEF, mem_addr=0x0010 -> LD record with addr 0x0010. Then a NOP cycle:
   - With TRACE_FILTER_NOP_EN, the next record's inum skips by 2.
6. rst_n pulsed low mid-drain:
   - rec_valid=0, all counters 0 and sticky flags clear with no clock edge required.
